register_file_4w_32b_1r_128b: RTL and testbench

Flip-flop register file, inverse of the wide-write/narrow-read SCM: N_WRITE independent 32-bit write ports fill sub-words of 128-bit rows; one 128-bit read port returns a full row. It sits between the per-core 32-bit producers (e.g. DMA/core store paths) and a wide consumer (vector/cache line fetch) that reads whole rows. Writes are staged one cycle, then committed; colliding writes to the same sub-word are resolved by fixed priority and reported.

---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file_4w_32b_1r_128b_rf_wport_stage.sv | 29 ++
 rtl/register_file_4w_32b_1r_128b.sv | 80 ++++++++
 tb/tb_register_file_4w_32b_1r_128b.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared geometry and write-stage entry type for the 4-write / 1-wide-read register file.
package register_file_pkg;
    localparam int WDATA_W   = 32;
    localparam int RDATA_W   = 128;
    localparam int RADDR_W   = 5;
    localparam int NUM_LANES = RDATA_W / WDATA_W;
    localparam int LANE_BITS = $clog2(NUM_LANES);
    localparam int NUM_ROWS  = 2 ** RADDR_W;
    localparam int WADDR_W   = RADDR_W + LANE_BITS;

    typedef struct packed {
        logic               valid;
        logic [WADDR_W-1:0] addr;
        logic [WDATA_W-1:0] data;
    } wr_stage_t;
endpackage

// File: rtl/register_file_4w_32b_1r_128b_rf_wport_stage.sv
// One write port's staging register: holds an accepted write for one cycle
// and flags a write that lost a same-address collision.
module rf_wport_stage
    import register_file_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               lost,
    input  logic [WADDR_W-1:0] addr,
    input  logic [WDATA_W-1:0] data,
    output wr_stage_t          entry,
    output logic               drop
);
    always_ff @(posedge clk) begin
        if (rst) begin
            entry.valid <= 1'b0;
            drop        <= 1'b0;
        end else begin
            entry.valid <= wr_en & ~lost;
            drop        <= wr_en & lost;
            // payload only moves when the write is accepted; valid guards it otherwise
            if (wr_en && !lost) begin
                entry.addr <= addr;
                entry.data <= data;
            end
        end
    end
endmodule

// File: rtl/register_file_4w_32b_1r_128b.sv
// Flip-flop register file: N_WRITE staged 32-bit write ports merge into
// 128-bit rows; one registered-address read port returns a whole row.
module register_file_4w_32b_1r_128b
    import register_file_pkg::*;
#(
    parameter int RADDR_WIDTH = RADDR_W,
    parameter int RDATA_WIDTH = RDATA_W,
    parameter int WDATA_WIDTH = WDATA_W,
    parameter int WADDR_WIDTH = RADDR_WIDTH + $clog2(RDATA_WIDTH / WDATA_WIDTH),
    parameter int N_WRITE     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_WRITE-1:0]                    WriteEnable,
    input  logic [N_WRITE-1:0][WADDR_WIDTH-1:0]   WriteAddr,
    input  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]   WriteData,
    output logic [N_WRITE-1:0]                    WriteDrop,
    input  logic                                  ReadEnable,
    input  logic [RADDR_WIDTH-1:0]                ReadAddr,
    output logic [RDATA_WIDTH-1:0]                ReadData,
    output logic                                  ReadValid
);
    logic [N_WRITE-1:0] lost;
    wr_stage_t          stage [N_WRITE];
    logic [NUM_LANES-1:0][WDATA_WIDTH-1:0] mem [NUM_ROWS];
    logic [RADDR_WIDTH-1:0] raddr;

    // A port loses when any lower-index port targets the same sub-word this cycle.
    always_comb begin
        lost = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            for (int q = 0; q < N_WRITE; q++) begin
                if (q < p && WriteEnable[p] && WriteEnable[q] &&
                    WriteAddr[p] == WriteAddr[q]) begin
                    lost[p] = 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < N_WRITE; p++) begin : g_port
        rf_wport_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .wr_en (WriteEnable[p]),
            .lost  (lost[p]),
            .addr  (WriteAddr[p]),
            .data  (WriteData[p]),
            .entry (stage[p]),
            .drop  (WriteDrop[p])
        );
    end

    // Staged entries never share a sub-word, so lane writes to one row merge cleanly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (stage[p].valid) begin
                    mem[stage[p].addr[WADDR_WIDTH-1:LANE_BITS]][stage[p].addr[LANE_BITS-1:0]]
                        <= stage[p].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr     <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= ReadEnable;
            if (ReadEnable) begin
                raddr <= ReadAddr;
            end
        end
    end

    // Combinational from the held address so later commits to that row show up.
    assign ReadData = mem[raddr];
endmodule

// File: tb/tb_register_file_4w_32b_1r_128b.sv
// Directed self-checking bench for register_file_4w_32b_1r_128b.
module tb_register_file_4w_32b_1r_128b;
    logic              clk;
    logic              rst;
    logic [3:0]        WriteEnable;
    logic [3:0][6:0]   WriteAddr;
    logic [3:0][31:0]  WriteData;
    logic [3:0]        WriteDrop;
    logic              ReadEnable;
    logic [4:0]        ReadAddr;
    logic [127:0]      ReadData;
    logic              ReadValid;

    int n_cmp = 0;
    int n_err = 0;

    register_file_4w_32b_1r_128b dut (
        .clk         (clk),
        .rst         (rst),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .WriteDrop   (WriteDrop),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .ReadValid   (ReadValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WriteEnable = '0;
        WriteAddr   = '0;
        WriteData   = '0;
        ReadEnable  = 1'b0;
        ReadAddr    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_cmp++;
        if (ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rvalid: got %b want 0", ReadValid);
        end
        n_cmp++;
        if (WriteDrop !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_drop: got %b want 0000", WriteDrop);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        WriteEnable[0] = 1'b1;
        WriteAddr[0]   = 7'h00;
        WriteData[0]   = 32'hA5A5A5A5;
        ReadEnable     = 1'b1;
        ReadAddr       = 5'd0;
        tick();
        idle();
        n_cmp++;
        if (ReadValid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_rvalid_t1: got %b want 1", ReadValid);
        end
        tick();
        n_cmp++;
        if (ReadData[31:0] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL basic_rdata_t2: got %h want a5a5a5a5", ReadData[31:0]);
        end
        n_cmp++;
        if (ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_rvalid_t2: got %b want 0", ReadValid);
        end
    endtask

    task automatic test_merge();
        WriteEnable = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            WriteAddr[p] = 7'h10 + 7'(p);
            WriteData[p] = 32'h11111111 * (p + 1);
        end
        tick();
        idle();
        n_cmp++;
        if (WriteDrop !== 4'b0000) begin
            n_err++;
            $display("FAIL merge_drop: got %b want 0000", WriteDrop);
        end
        ReadEnable = 1'b1;
        ReadAddr   = 5'd4;
        tick();
        idle();
        n_cmp++;
        if (ReadData !== 128'h44444444_33333333_22222222_11111111) begin
            n_err++;
            $display("FAIL merge_row4: got %h want 44444444333333332222222211111111", ReadData);
        end
    endtask

    task automatic test_collision();
        WriteEnable[1] = 1'b1;
        WriteAddr[1]   = 7'h05;
        WriteData[1]   = 32'hDEAD0001;
        WriteEnable[3] = 1'b1;
        WriteAddr[3]   = 7'h05;
        WriteData[3]   = 32'hDEAD0003;
        tick();
        idle();
        n_cmp++;
        if (WriteDrop !== 4'b1000) begin
            n_err++;
            $display("FAIL collide_drop: got %b want 1000", WriteDrop);
        end
        ReadEnable = 1'b1;
        ReadAddr   = 5'd1;
        tick();
        idle();
        n_cmp++;
        if (WriteDrop !== 4'b0000) begin
            n_err++;
            $display("FAIL collide_drop_clear: got %b want 0000", WriteDrop);
        end
        n_cmp++;
        if (ReadData[63:32] !== 32'hDEAD0001) begin
            n_err++;
            $display("FAIL collide_lane: got %h want dead0001", ReadData[63:32]);
        end
    endtask

    task automatic test_read_during_write();
        WriteEnable[0] = 1'b1;
        WriteAddr[0]   = 7'h08;
        WriteData[0]   = 32'h12345678;
        tick();
        idle();
        tick();
        WriteEnable[2] = 1'b1;
        WriteAddr[2]   = 7'h08;
        WriteData[2]   = 32'hCAFEF00D;
        ReadEnable     = 1'b1;
        ReadAddr       = 5'd2;
        tick();
        idle();
        n_cmp++;
        if (ReadData[31:0] !== 32'h12345678) begin
            n_err++;
            $display("FAIL rdw_old: got %h want 12345678", ReadData[31:0]);
        end
        tick();
        n_cmp++;
        if (ReadData[31:0] !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL rdw_new: got %h want cafef00d", ReadData[31:0]);
        end
    endtask

    task automatic test_reset_drops_pending();
        WriteEnable[0] = 1'b1;
        WriteAddr[0]   = 7'h7C;
        WriteData[0]   = 32'h0BADBEEF;
        tick();
        idle();
        tick();
        // pending write plus a collision loser, then reset before commit
        WriteEnable[1:0] = 2'b11;
        WriteAddr[0]     = 7'h7C;
        WriteData[0]     = 32'hFFFFFFFF;
        WriteAddr[1]     = 7'h7C;
        WriteData[1]     = 32'hEEEEEEEE;
        ReadEnable       = 1'b1;
        ReadAddr         = 5'd31;
        tick();
        rst            = 1'b1;
        WriteEnable    = 4'b0001;
        WriteData[0]   = 32'h22222222;
        ReadEnable     = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_cmp++;
        if (ReadValid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rvalid: got %b want 0", ReadValid);
        end
        n_cmp++;
        if (WriteDrop !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_drop: got %b want 0000", WriteDrop);
        end
        n_cmp++;
        if (ReadData[31:0] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL rst_raddr_row0: got %h want a5a5a5a5", ReadData[31:0]);
        end
        tick();
        ReadEnable = 1'b1;
        ReadAddr   = 5'd31;
        tick();
        idle();
        n_cmp++;
        if (ReadData[31:0] !== 32'h0BADBEEF) begin
            n_err++;
            $display("FAIL rst_row31: got %h want 0badbeef", ReadData[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_row;
        for (int i = 0; i < 128; i++) begin
            WriteEnable[0] = 1'b1;
            WriteAddr[0]   = 7'(i);
            WriteData[0]   = 32'hC0DE0000 | 32'(i);
            tick();
            if (i > 0) begin
                n_cmp++;
                if (WriteDrop !== 4'b0000) begin
                    n_err++;
                    $display("FAIL b2b_drop[%0d]: got %b want 0000", i, WriteDrop);
                end
            end
        end
        idle();
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            ReadEnable = 1'b1;
            ReadAddr   = 5'(r);
            tick();
            for (int l = 0; l < 4; l++) begin
                exp_row[l*32 +: 32] = 32'hC0DE0000 | 32'(4 * r + l);
            end
            n_cmp++;
            if (ReadData !== exp_row || ReadValid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_row[%0d]: got %h v=%b want %h v=1", r, ReadData, ReadValid, exp_row);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_merge();
        test_collision();
        test_read_during_write();
        test_reset_drops_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
